multdiv_seq: RTL and testbench

MULTDIV_SEQ -- requirements
Module: multdiv_seq

---
 rtl/multdiv_seq.sv | 88 ++++++++
 tb/tb_multdiv_seq.sv | 108 ++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed 32-bit multiplier / divider, fixed 33-cycle latency
// Ports: clock/reset (sync, active-high); data_operandA/B operands latched on a start strobe;
//        ctrl_MULT/ctrl_DIV start strobes (MULT wins); data_result/data_exception held from DONE;
//        data_resultRDY one-cycle completion pulse; multdiv_is_running high while iterating.
module multdiv_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        multdiv_is_running
);
   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [63:0] r_x, r_acc;
   logic [31:0] r_y, r_res;
   logic        r_neg, r_dz, r_exc, r_rdy, r_run;
   logic [31:0] w_abs_a, w_abs_b;
   logic [32:0] w_shift, w_sub;
   logic        w_ge, w_mexc;
   logic [63:0] w_addend;
   always_comb begin
      w_abs_a  = data_operandA[31] ? -data_operandA : data_operandA;
      w_abs_b  = data_operandB[31] ? -data_operandB : data_operandB;
      w_shift  = {r_acc[31:0], r_y[31]};
      w_sub    = w_shift - {1'b0, r_x[31:0]};
      w_ge     = w_shift >= {1'b0, r_x[31:0]};
      // multiplier bit 31 carries weight -2^31 in two's complement
      w_addend = r_y[0] ? ((r_cnt == 6'd31) ? -r_x : r_x) : 64'd0;
      w_mexc   = !((&r_acc[63:31]) | ~(|r_acc[63:31]));
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_x     <= '0;
         r_acc   <= '0;
         r_y     <= '0;
         r_res   <= '0;
         r_neg   <= 1'b0;
         r_dz    <= 1'b0;
         r_exc   <= 1'b0;
         r_rdy   <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         if (ctrl_MULT || ctrl_DIV) begin
            r_state <= ctrl_MULT ? MULT : DIV;
            r_cnt   <= '0;
            r_run   <= 1'b1;
            r_acc   <= '0;
            r_x     <= ctrl_MULT ? {{32{data_operandA[31]}}, data_operandA} : {32'd0, w_abs_b};
            r_y     <= ctrl_MULT ? data_operandB : w_abs_a;
            r_neg   <= data_operandA[31] ^ data_operandB[31];
            r_dz    <= data_operandB == 32'd0;
         end else if (r_state == MULT || r_state == DIV) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd32) begin
               // 33rd cycle: iterations are done, publish the result
               r_state <= DONE;
               r_rdy   <= 1'b1;
               r_run   <= 1'b0;
               r_res   <= (r_state == MULT) ? r_acc[31:0] : r_dz ? 32'd0 : r_neg ? -r_y : r_y;
               r_exc   <= (r_state == MULT) ? w_mexc : r_dz | (!r_neg & r_y[31]);
            end else if (r_state == MULT) begin
               r_acc <= r_acc + w_addend;
               r_x   <= r_x << 1;
               r_y   <= r_y >> 1;
            end else begin
               // restoring step: r_y shifts dividend bits out and quotient bits in
               r_acc <= {32'd0, w_ge ? w_sub[31:0] : w_shift[31:0]};
               r_y   <= {r_y[30:0], w_ge};
            end
         end else if (r_state == DONE) begin
            r_state <= IDLE;
         end
      end
   end
   assign data_result        = r_res;
   assign data_exception     = r_exc;
   assign data_resultRDY     = r_rdy;
   assign multdiv_is_running = r_run;
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed scoreboard bench for multdiv_seq
module tb_multdiv_seq;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, multdiv_is_running;
   int          tests = 0, fails = 0;
   logic [32:0] sb[$];
   multdiv_seq dut (
      .clock(clock), .reset(reset),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .multdiv_is_running(multdiv_is_running)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // called at a negedge; the following posedge samples the strobe, returns at the negedge after it
   task automatic strobe(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask
   // starts at the negedge after E0, checks the whole fixed-latency window
   task automatic expect_done(input string tag);
      logic        bad = 1'b0;
      logic [32:0] e;
      for (int k = 0; k <= 32; k++) begin
         if (k > 0) @(negedge clock);
         if (data_resultRDY !== 1'b0 || multdiv_is_running !== 1'b1) bad = 1'b1;
      end
      chk({tag, " busy window"}, {31'd0, bad}, 32'd0);
      @(negedge clock);
      chk({tag, " rdy"}, {31'd0, data_resultRDY}, 32'd1);
      chk({tag, " running off"}, {31'd0, multdiv_is_running}, 32'd0);
      e = (sb.size() > 0) ? sb.pop_front() : 33'h1_DEAD_BEEF;
      chk({tag, " result"}, data_result, e[32:1]);
      chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, e[0]});
      @(negedge clock);
      chk({tag, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
      chk({tag, " result held"}, data_result, e[32:1]);
   endtask
   task automatic op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic x);
      sb.push_back({r, x});
      strobe(m, !m, a, b);
      expect_done(tag);
   endtask
   initial begin
      logic bad;
      repeat (2) @(negedge clock);
      chk("reset result", data_result, 32'd0);
      chk("reset flags", {28'd0, data_exception, data_resultRDY, multdiv_is_running, 1'b0}, 32'd0);
      reset = 1'b0;
      op("mul 7*-3", 1'b1, 32'd7, -32'sd3, 32'hFFFFFFEB, 1'b0);
      op("mul ovf", 1'b1, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
      op("mul -5*-5", 1'b1, -32'sd5, -32'sd5, 32'd25, 1'b0);
      op("mul minint*1", 1'b1, 32'h80000000, 32'd1, 32'h80000000, 1'b0);
      op("mul 2^16*2^16", 1'b1, 32'h10000, 32'h10000, 32'd0, 1'b1);
      op("div -20/6", 1'b0, -32'sd20, 32'd6, 32'hFFFFFFFD, 1'b0);
      op("div 20/-6", 1'b0, 32'd20, -32'sd6, 32'hFFFFFFFD, 1'b0);
      op("div -7/2", 1'b0, -32'sd7, 32'd2, 32'hFFFFFFFD, 1'b0);
      op("div max/1", 1'b0, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0);
      op("div by 0", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1);
      op("div minint/-1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      sb.push_back({32'd42, 1'b0});
      strobe(1'b1, 1'b1, 32'd6, 32'd7);
      expect_done("both strobes");
      // reset at E0+10 aborts the multiply
      strobe(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort reset result", data_result, 32'd0);
      chk("abort reset flags", {29'd0, data_exception, data_resultRDY, multdiv_is_running}, 32'd0);
      bad = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY !== 1'b0 || multdiv_is_running !== 1'b0) bad = 1'b1;
      end
      chk("no rdy after reset", {31'd0, bad}, 32'd0);
      op("div 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
      // DIV strobed at E0+5 replaces the multiply
      strobe(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (4) @(negedge clock);
      sb.push_back({32'd3, 1'b0});
      strobe(1'b0, 1'b1, 32'd9, 32'd3);
      expect_done("restart div 9/3");
      chk("scoreboard drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
